// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg: ID/EX pipeline register with valid/ready flow control and a one-entry skid buffer.
// It also supports a synchronous flush and counts stalled cycles in a saturating counter.
// Ports:
//   clk, rst_n                  clock and asynchronous active-low reset
//   flush                       drops the held bundle and any bundle arriving in the same cycle
//   in_valid / in_ready         handshake on the decode side; in_ready comes from a flop
//   in_pc_plus4 .. in_ctrl      bundle fields arriving from decode
//   out_valid / out_ready       handshake on the execute side; out_valid comes from a flop
//   out_pc_plus4 .. out_ctrl    registered bundle fields presented to execute
//   stall_cnt                   saturating count of edges with out_valid=1 and out_ready=0
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_pc_plus4,
  input  logic [DATA_W-1:0] in_rd1,
  input  logic [DATA_W-1:0] in_rd2,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_pc_plus4,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);
  localparam int W = 4*DATA_W + 2*REG_W + CTRL_W;
  // Bit 0 set means the main register holds data and bit 1 set means the skid register does.
  // This lets out_valid and in_ready come straight from the state flops.
  typedef enum logic [1:0] {EMPTY = 2'b00, FULL = 2'b01, SKID = 2'b11} state_t;
  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_main;
  logic [W-1:0]   r_skid;
  logic [W-1:0]   w_in;
  logic [CNT_W-1:0] r_stall_cnt;
  logic           w_in_fire;
  logic           w_out_fire;
  logic           w_load_main;
  logic           w_load_skid;
  assign w_in = {in_pc_plus4, in_rd1, in_rd2, in_imm, in_rt, in_rd, in_ctrl};
  assign {out_pc_plus4, out_rd1, out_rd2, out_imm, out_rt, out_rd, out_ctrl} = r_main;
  assign stall_cnt = r_stall_cnt;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= EMPTY;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (flush) w_next = EMPTY;
    else
      case (r_state)
        EMPTY:   w_next = w_in_fire ? FULL : EMPTY;
        FULL:    w_next = (w_in_fire && !w_out_fire) ? SKID :
                          (!w_in_fire && w_out_fire) ? EMPTY : FULL;
        SKID:    w_next = w_out_fire ? FULL : SKID;
        default: w_next = EMPTY;
      endcase
  end
  always_comb begin
    out_valid   = r_state[0];
    in_ready    = ~r_state[1];
    // A flush blocks every payload load, so out_* keep their last value while the stage is empty.
    w_load_main = !flush && ((r_state == EMPTY && w_in_fire) ||
                             (r_state == FULL  && w_in_fire && w_out_fire) ||
                             (r_state == SKID  && w_out_fire));
    w_load_skid = !flush && r_state == FULL && w_in_fire && !w_out_fire;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      // When the skid register drains, it refills main first, so skid data never overtakes main data.
      if (w_load_main) r_main <= (r_state == SKID) ? r_skid : w_in;
      if (w_load_skid) r_skid <= w_in;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_stall_cnt <= '0;
    else if (out_valid && !out_ready && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb_id_ex_stage_reg: checks id_ex_stage_reg against a queue model and against hand-computed values.
module tb_id_ex_stage_reg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } bun_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  bun_t din = '0;
  logic in_ready, out_valid;
  logic [31:0] o_pc, o_rd1, o_rd2, o_imm;
  logic [4:0] o_rt, o_rd;
  logic [7:0] o_ctrl;
  logic [15:0] stall_cnt;
  logic s_flush = 0, s_in_valid = 0, s_out_ready = 0;
  logic [15:0] s_imm = '0;
  logic [4:0] s_rd = '0;
  logic s_in_ready, s_out_valid;
  logic [15:0] s_o_pc, s_o_rd1, s_o_rd2, s_o_imm;
  logic [4:0] s_o_rt, s_o_rd;
  logic [7:0] s_o_ctrl;
  logic [3:0] s_cnt;
  int n_chk = 0, n_pass = 0;
  bun_t q[$];
  bun_t shown = '0;
  int m_cnt = 0;

  id_ex_stage_reg dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc_plus4(din.pc), .in_rd1(din.rd1), .in_rd2(din.rd2), .in_imm(din.imm),
    .in_rt(din.rt), .in_rd(din.rd), .in_ctrl(din.ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc_plus4(o_pc), .out_rd1(o_rd1), .out_rd2(o_rd2), .out_imm(o_imm),
    .out_rt(o_rt), .out_rd(o_rd), .out_ctrl(o_ctrl), .stall_cnt(stall_cnt));

  id_ex_stage_reg #(.DATA_W(16), .REG_W(5), .CTRL_W(8), .CNT_W(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_pc_plus4(16'h1234), .in_rd1(16'h00aa), .in_rd2(16'hbeef), .in_imm(s_imm),
    .in_rt(5'd7), .in_rd(s_rd), .in_ctrl(8'h5a),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_pc_plus4(s_o_pc), .out_rd1(s_o_rd1), .out_rd2(s_o_rd2), .out_imm(s_o_imm),
    .out_rt(s_o_rt), .out_rd(s_o_rd), .out_ctrl(s_o_ctrl), .stall_cnt(s_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic bun_t mk(input int k);
    bun_t b;
    b.pc   = 32'h0040_0000 + 32'(4*k);
    b.rd1  = 32'(k);
    b.rd2  = 32'(3*k + 7);
    b.imm  = k[0] ? (32'hffff_0000 | 32'(k)) : 32'(k);
    b.rt   = 5'(k);
    b.rd   = 5'(k + 3);
    b.ctrl = 8'ha0 ^ 8'(k);
    return b;
  endfunction

  // The model is a FIFO of at most two bundles, and the head of the FIFO is what execute sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      shown = '0;
      m_cnt = 0;
    end else begin
      automatic bit ov = q.size() > 0;
      automatic bit inf = in_valid && q.size() < 2;
      if (ov && !out_ready && m_cnt < 65535) m_cnt++;
      if (flush) q.delete();
      else begin
        if (ov && out_ready) void'(q.pop_front());
        if (inf) q.push_back(din);
      end
      if (q.size() > 0) shown = q[0];
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("model out_valid", 160'(out_valid), 160'(q.size() > 0));
    chk("model in_ready", 160'(in_ready), 160'(q.size() < 2));
    chk("model payload", 160'({o_pc, o_rd1, o_rd2, o_imm, o_rt, o_rd, o_ctrl}), 160'(shown));
    chk("model stall_cnt", 160'(stall_cnt), 160'(m_cnt));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int k);
    in_valid = 1;
    din = mk(k);
  endtask

  initial begin
    step();
    step();
    rst_n = 1;
    step();
    out_ready = 1;
    for (int k = 1; k <= 8; k++) begin
      send(k);
      step();
      chk("stream rd1", 160'(o_rd1), 160'(k));
      chk("stream in_ready", 160'(in_ready), 160'(1));
    end
    in_valid = 0;
    step();
    chk("stream drained", 160'(out_valid), 160'(0));
    chk("stream stall_cnt", 160'(stall_cnt), 160'(0));
    chk("stream last rd1 kept", 160'(o_rd1), 160'(8));
    out_ready = 0;
    send(9);
    step();
    in_valid = 0;
    step();
    #1 rst_n = 0;
    #1;
    chk("reset out_valid", 160'(out_valid), 160'(0));
    chk("reset in_ready", 160'(in_ready), 160'(1));
    chk("reset out_rd1", 160'(o_rd1), 160'(0));
    chk("reset stall_cnt", 160'(stall_cnt), 160'(0));
    step();
    rst_n = 1;
    step();
    send(10);
    step();
    chk("bp A shown", 160'(o_rd1), 160'(10));
    send(11);
    step();
    chk("bp skid in_ready", 160'(in_ready), 160'(0));
    in_valid = 0;
    step();
    step();
    chk("bp stall_cnt", 160'(stall_cnt), 160'(3));
    chk("bp A held", 160'(o_rd1), 160'(10));
    out_ready = 1;
    step();
    chk("bp B shown", 160'(o_rd1), 160'(11));
    chk("bp in_ready back", 160'(in_ready), 160'(1));
    step();
    chk("bp drained", 160'(out_valid), 160'(0));
    out_ready = 0;
    send(20);
    step();
    send(21);
    step();
    send(22);
    flush = 1;
    step();
    chk("flush out_valid", 160'(out_valid), 160'(0));
    chk("flush in_ready", 160'(in_ready), 160'(1));
    chk("flush stall_cnt kept", 160'(stall_cnt), 160'(5));
    flush = 0;
    in_valid = 0;
    step();
    chk("flush stays empty", 160'(out_valid), 160'(0));
    out_ready = 1;
    send(23);
    step();
    chk("D valid", 160'(out_valid), 160'(1));
    chk("D rd1", 160'(o_rd1), 160'(23));
    in_valid = 0;
    step();
    chk("D consumed", 160'(out_valid), 160'(0));
    s_in_valid = 1;
    s_imm = 16'h8001;
    s_rd = 5'd31;
    step();
    s_in_valid = 0;
    chk("w16 imm", 160'(s_o_imm), 160'(16'h8001));
    chk("w16 rd", 160'(s_o_rd), 160'(5'd31));
    chk("w16 pc", 160'(s_o_pc), 160'(16'h1234));
    chk("w16 valid", 160'(s_out_valid), 160'(1));
    for (int i = 0; i < 5; i++) step();
    chk("sat mid", 160'(s_cnt), 160'(5));
    for (int i = 0; i < 15; i++) step();
    chk("sat cnt", 160'(s_cnt), 160'(15));
    chk("sat held imm", 160'(s_o_imm), 160'(16'h8001));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
